// File: rtl/axis_packet_arbiter_pkg.sv
// Shared definitions for the two-port AXI4-Stream packet arbiter:
// default payload widths, port index constants, FSM state type and the
// grant selection helper.
package axis_packet_arbiter_pkg;

  localparam int unsigned W_DATA  = 512;
  localparam int unsigned W_KEEP  = W_DATA / 8;
  localparam int unsigned W_CNT   = 32;
  localparam int unsigned N_PORTS = 2;

  localparam logic PORT_DMA = 1'b0;
  localparam logic PORT_PHY = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Pick the winning port from the eligible mask. Only meaningful when at
  // least one bit of elig is set. Strict: lowest index wins. Round-robin:
  // rr_ptr wins if eligible, otherwise the other port.
  function automatic logic pick_winner(input logic [1:0] elig,
                                       input logic       rr_ptr,
                                       input logic       strict);
    logic win;
    if (strict) begin
      win = elig[PORT_DMA] ? PORT_DMA : PORT_PHY;
    end else begin
      win = elig[rr_ptr] ? rr_ptr : ~rr_ptr;
    end
    return win;
  endfunction

endpackage

// File: rtl/axis_output_reg.sv
// Registered output stage of the arbiter. A beat presented with load=1 is
// captured on the same edge and shown on m_axis_* the next cycle. The
// payload is held stable while m_axis_tvalid=1 and m_axis_tready=0; the
// valid flag clears once the beat is drained and nothing new is loaded.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              capture in_* this edge (caller guarantees space)
//   in_tdata/tkeep/tlast/tdest   beat to capture
//   m_axis_tready     downstream ready
//   m_axis_tvalid/tdata/tkeep/tlast/tdest   registered output beat
module axis_output_reg #(
  parameter int unsigned W_DATA = axis_packet_arbiter_pkg::W_DATA,
  parameter int unsigned W_KEEP = W_DATA / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [W_DATA-1:0] in_tdata,
  input  logic [W_KEEP-1:0] in_tkeep,
  input  logic              in_tlast,
  input  logic              in_tdest,
  input  logic              m_axis_tready,
  output logic              m_axis_tvalid,
  output logic [W_DATA-1:0] m_axis_tdata,
  output logic [W_KEEP-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tdest
);

  import axis_packet_arbiter_pkg::*;

  // Valid flag: set on load, cleared when the held beat is drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Payload only changes on load, so it stays put under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tdest <= 1'b0;
    end else if (load) begin
      m_axis_tdata <= in_tdata;
      m_axis_tkeep <= in_tkeep;
      m_axis_tlast <= in_tlast;
      m_axis_tdest <= in_tdest;
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Two-port AXI4-Stream packet arbiter. Port 0 (DMA) and port 1 (PHY) are
// merged onto one output stream at packet granularity: once a port is
// granted it owns the output until its tlast beat is accepted.
// Round-robin or strict priority (port 0 highest) selection, per-port
// enable mask, per-port forwarded-packet counters.
//
// Ports:
//   axis_aclk, axis_rst        clock, asynchronous active-high reset
//   s_axis_*  [port]           two slave streams (valid/ready/last/data/keep)
//   m_axis_*                   merged master stream; tdest = source port
//   cfg_enable                 per-port enable mask
//   cfg_strict                 0 = round-robin, 1 = strict priority
//   pkt_count [port]           forwarded packets per port (wrapping)
module axis_packet_arbiter #(
  parameter int unsigned W_DATA = axis_packet_arbiter_pkg::W_DATA,
  parameter int unsigned W_KEEP = W_DATA / 8,
  parameter int unsigned W_CNT  = axis_packet_arbiter_pkg::W_CNT
) (
  input  logic                   axis_aclk,
  input  logic                   axis_rst,
  input  logic [1:0]             s_axis_tvalid,
  output logic [1:0]             s_axis_tready,
  input  logic [1:0]             s_axis_tlast,
  input  logic [1:0][W_DATA-1:0] s_axis_tdata,
  input  logic [1:0][W_KEEP-1:0] s_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [W_DATA-1:0]      m_axis_tdata,
  output logic [W_KEEP-1:0]      m_axis_tkeep,
  output logic                   m_axis_tdest,
  input  logic [1:0]             cfg_enable,
  input  logic                   cfg_strict,
  output logic [1:0][W_CNT-1:0]  pkt_count
);

  import axis_packet_arbiter_pkg::*;

  state_t                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   rr_ptr_q, rr_ptr_d;
  logic [1:0][W_CNT-1:0]  cnt_q, cnt_d;
  logic [1:0]             elig;
  logic                   out_ready;
  logic                   accept;

  // Output stage has room when empty or draining this cycle.
  assign out_ready = !m_axis_tvalid || m_axis_tready;
  assign elig      = s_axis_tvalid & cfg_enable;
  assign pkt_count = cnt_q;

  // State, grant, round-robin pointer and packet counters.
  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= PORT_DMA;
      rr_ptr_q <= PORT_DMA;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state, grant decision and per-port ready. Config inputs are only
  // looked at in IDLE, so changes mid-packet wait for the next decision.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    s_axis_tready = 2'b00;
    accept        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_d = ST_LOCKED;
          grant_d = pick_winner(elig, rr_ptr_q, cfg_strict);
        end
      end

      ST_LOCKED: begin
        s_axis_tready[grant_q] = out_ready;
        accept                 = s_axis_tvalid[grant_q] && out_ready;
        if (accept && s_axis_tlast[grant_q]) begin
          state_d        = ST_IDLE;
          rr_ptr_d       = ~grant_q;
          cnt_d[grant_q] = cnt_q[grant_q] + W_CNT'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  axis_output_reg #(
    .W_DATA (W_DATA),
    .W_KEEP (W_KEEP)
  ) u_out (
    .clk           (axis_aclk),
    .rst           (axis_rst),
    .load          (accept),
    .in_tdata      (s_axis_tdata[grant_q]),
    .in_tkeep      (s_axis_tkeep[grant_q]),
    .in_tlast      (s_axis_tlast[grant_q]),
    .in_tdest      (grant_q),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdest  (m_axis_tdest)
  );

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: a cycle table for the
// round-robin interleave, then directed sequences with a source model and
// an output scoreboard for strict priority, enable masking, backpressure,
// reset mid-packet, single-beat latency and counter wrap.
module tb_axis_packet_arbiter;

  localparam int unsigned W_DATA = 32;
  localparam int unsigned W_KEEP = 4;
  localparam int unsigned W_CNT  = 3;

  logic                   clk;
  logic                   rst;
  logic [1:0]             s_axis_tvalid;
  logic [1:0]             s_axis_tready;
  logic [1:0]             s_axis_tlast;
  logic [1:0][W_DATA-1:0] s_axis_tdata;
  logic [1:0][W_KEEP-1:0] s_axis_tkeep;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tlast;
  logic [W_DATA-1:0]      m_axis_tdata;
  logic [W_KEEP-1:0]      m_axis_tkeep;
  logic                   m_axis_tdest;
  logic [1:0]             cfg_enable;
  logic                   cfg_strict;
  logic [1:0][W_CNT-1:0]  pkt_count;

  axis_packet_arbiter #(
    .W_DATA (W_DATA),
    .W_KEEP (W_KEEP),
    .W_CNT  (W_CNT)
  ) dut (
    .axis_aclk     (clk),
    .axis_rst      (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tdest  (m_axis_tdest),
    .cfg_enable    (cfg_enable),
    .cfg_strict    (cfg_strict),
    .pkt_count     (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Round-robin table: en=11, strict=0, m_tready=1 throughout.
  typedef struct {
    logic [1:0] v;
    logic [1:0] l;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] sr;
    logic       mv;
    logic       ml;
    logic       mdest;
    logic [7:0] md;
    logic [2:0] c0;
    logic [2:0] c1;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic [1:0] v, logic [1:0] l, logic [7:0] d0, logic [7:0] d1,
                              logic [1:0] sr, logic mv, logic ml, logic mdest,
                              logic [7:0] md, logic [2:0] c0, logic [2:0] c1);
    vec_t r;
    r.v = v; r.l = l; r.d0 = d0; r.d1 = d1; r.sr = sr; r.mv = mv; r.ml = ml;
    r.mdest = mdest; r.md = md; r.c0 = c0; r.c1 = c1;
    return r;
  endfunction

  // Source model and scoreboard state.
  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       dest;
  } beat_t;

  beat_t       sb[$];
  logic [1:0]  src_on;
  int unsigned n_beat[2];
  int unsigned pkt_len[2];
  logic [7:0]  base[2];
  int unsigned pkt_exp[2];
  logic        mr_v;
  logic [1:0]  en_v;
  logic        st_v;
  int          only_dest;
  logic        chk_sr0;
  logic        hold_pending;
  logic [W_DATA-1:0] held_data;
  logic        held_last;
  logic        held_dest;

  function automatic logic [7:0] beat_byte(int p);
    return base[p] + 8'(n_beat[p]);
  endfunction

  function automatic logic cur_last(int p);
    return (n_beat[p] % pkt_len[p]) == (pkt_len[p] - 1);
  endfunction

  task automatic drive_gen();
    for (int p = 0; p < 2; p++) begin
      s_axis_tvalid[p] = src_on[p];
      s_axis_tdata[p]  = {4{beat_byte(p)}};
      s_axis_tkeep[p]  = (p == 1) ? 4'h3 : 4'hF;
      s_axis_tlast[p]  = cur_last(p);
    end
    cfg_enable    = en_v;
    cfg_strict    = st_v;
    m_axis_tready = mr_v;
  endtask

  // One cycle: drive at posedge+1, check at negedge, update model after edge.
  task automatic gstep();
    logic [1:0] acc;
    beat_t b;
    drive_gen();
    @(negedge clk);
    if (hold_pending) begin
      chk("hold_valid", 64'(m_axis_tvalid), 64'(1'b1));
      chk("hold_data", 64'(m_axis_tdata), 64'(held_data));
      chk("hold_last", 64'(m_axis_tlast), 64'(held_last));
      chk("hold_dest", 64'(m_axis_tdest), 64'(held_dest));
    end
    hold_pending = m_axis_tvalid && !m_axis_tready;
    held_data    = m_axis_tdata;
    held_last    = m_axis_tlast;
    held_dest    = m_axis_tdest;
    if (m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL extra_beat: got data %0h expected no beat", m_axis_tdata);
      end else begin
        b = sb.pop_front();
        chk("sb_data", 64'(m_axis_tdata), 64'({4{b.d}}));
        chk("sb_keep", 64'(m_axis_tkeep), 64'(b.dest ? 4'h3 : 4'hF));
        chk("sb_last", 64'(m_axis_tlast), 64'(b.l));
        chk("sb_dest", 64'(m_axis_tdest), 64'(b.dest));
        if (only_dest >= 0) chk("only_dest", 64'(m_axis_tdest), 64'(only_dest));
      end
    end
    if (chk_sr0) chk("sr0_disabled", 64'(s_axis_tready[0]), 64'(1'b0));
    acc = s_axis_tvalid & s_axis_tready;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) begin
        b.d    = beat_byte(p);
        b.l    = cur_last(p);
        b.dest = (p == 1);
        sb.push_back(b);
        if (b.l) pkt_exp[p]++;
        n_beat[p]++;
      end
    end
  endtask

  task automatic apply_reset();
    rst           = 1'b1;
    s_axis_tvalid = 2'b00;
    s_axis_tlast  = 2'b00;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    m_axis_tready = 1'b1;
    cfg_enable    = 2'b11;
    cfg_strict    = 1'b0;
    src_on        = 2'b00;
    en_v          = 2'b11;
    st_v          = 1'b0;
    mr_v          = 1'b1;
    only_dest     = -1;
    chk_sr0       = 1'b0;
    hold_pending  = 1'b0;
    sb.delete();
    for (int p = 0; p < 2; p++) begin
      n_beat[p]  = 0;
      pkt_len[p] = 1;
      base[p]    = 8'h00;
      pkt_exp[p] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_mv"}, 64'(m_axis_tvalid), 64'(1'b0));
    chk({tag, "_ml"}, 64'(m_axis_tlast), 64'(1'b0));
    chk({tag, "_md"}, 64'(m_axis_tdata), 64'(0));
    chk({tag, "_mk"}, 64'(m_axis_tkeep), 64'(0));
    chk({tag, "_mdest"}, 64'(m_axis_tdest), 64'(1'b0));
    chk({tag, "_sr"}, 64'(s_axis_tready), 64'(2'b00));
    chk({tag, "_cnt"}, 64'(pkt_count), 64'(0));
  endtask

  initial begin
    tbl[0]  = mk(2'b11, 2'b00, 8'h01, 8'h11, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0);
    tbl[1]  = mk(2'b11, 2'b00, 8'h01, 8'h11, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0);
    tbl[2]  = mk(2'b11, 2'b00, 8'h02, 8'h11, 2'b01, 1'b1, 1'b0, 1'b0, 8'h01, 3'd0, 3'd0);
    tbl[3]  = mk(2'b11, 2'b01, 8'h03, 8'h11, 2'b01, 1'b1, 1'b0, 1'b0, 8'h02, 3'd0, 3'd0);
    tbl[4]  = mk(2'b11, 2'b00, 8'h04, 8'h11, 2'b00, 1'b1, 1'b1, 1'b0, 8'h03, 3'd1, 3'd0);
    tbl[5]  = mk(2'b11, 2'b00, 8'h04, 8'h11, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 3'd0);
    tbl[6]  = mk(2'b11, 2'b00, 8'h04, 8'h12, 2'b10, 1'b1, 1'b0, 1'b1, 8'h11, 3'd1, 3'd0);
    tbl[7]  = mk(2'b11, 2'b10, 8'h04, 8'h13, 2'b10, 1'b1, 1'b0, 1'b1, 8'h12, 3'd1, 3'd0);
    tbl[8]  = mk(2'b11, 2'b00, 8'h04, 8'h14, 2'b00, 1'b1, 1'b1, 1'b1, 8'h13, 3'd1, 3'd1);
    tbl[9]  = mk(2'b11, 2'b00, 8'h04, 8'h14, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 3'd1);
    tbl[10] = mk(2'b11, 2'b00, 8'h05, 8'h14, 2'b01, 1'b1, 1'b0, 1'b0, 8'h04, 3'd1, 3'd1);
    tbl[11] = mk(2'b11, 2'b01, 8'h06, 8'h14, 2'b01, 1'b1, 1'b0, 1'b0, 8'h05, 3'd1, 3'd1);
    tbl[12] = mk(2'b00, 2'b00, 8'h07, 8'h14, 2'b00, 1'b1, 1'b1, 1'b0, 8'h06, 3'd2, 3'd1);
    tbl[13] = mk(2'b00, 2'b00, 8'h07, 8'h14, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd2, 3'd1);

    // Values while reset is held.
    rst           = 1'b1;
    s_axis_tvalid = 2'b11;
    s_axis_tlast  = 2'b00;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    m_axis_tready = 1'b1;
    cfg_enable    = 2'b11;
    cfg_strict    = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_values("por");

    // Round-robin interleave of 3-beat packets.
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      s_axis_tvalid   = tbl[i].v;
      s_axis_tlast    = tbl[i].l;
      s_axis_tdata[0] = {4{tbl[i].d0}};
      s_axis_tdata[1] = {4{tbl[i].d1}};
      s_axis_tkeep[0] = 4'hF;
      s_axis_tkeep[1] = 4'h3;
      @(negedge clk);
      chk($sformatf("rr%0d_sr", i), 64'(s_axis_tready), 64'(tbl[i].sr));
      chk($sformatf("rr%0d_mv", i), 64'(m_axis_tvalid), 64'(tbl[i].mv));
      chk($sformatf("rr%0d_c0", i), 64'(pkt_count[0]), 64'(tbl[i].c0));
      chk($sformatf("rr%0d_c1", i), 64'(pkt_count[1]), 64'(tbl[i].c1));
      if (tbl[i].mv) begin
        chk($sformatf("rr%0d_ml", i), 64'(m_axis_tlast), 64'(tbl[i].ml));
        chk($sformatf("rr%0d_dest", i), 64'(m_axis_tdest), 64'(tbl[i].mdest));
        chk($sformatf("rr%0d_md", i), 64'(m_axis_tdata), 64'({4{tbl[i].md}}));
      end
      @(posedge clk);
      #1;
    end

    // Strict priority: port 0 always wins, port 1 starves.
    apply_reset();
    src_on     = 2'b11;
    pkt_len[0] = 2;
    pkt_len[1] = 2;
    base[0]    = 8'h10;
    base[1]    = 8'h80;
    st_v       = 1'b1;
    only_dest  = 0;
    repeat (30) gstep();
    chk("strict_c1", 64'(pkt_count[1]), 64'(0));
    chk("strict_c0", 64'(pkt_count[0]), 64'(3'(pkt_exp[0])));

    // Port 0 disabled: never ready, only port 1 forwarded.
    apply_reset();
    src_on     = 2'b11;
    pkt_len[0] = 3;
    pkt_len[1] = 3;
    base[0]    = 8'h20;
    base[1]    = 8'h90;
    en_v       = 2'b10;
    only_dest  = 1;
    chk_sr0    = 1'b1;
    repeat (25) gstep();
    chk("en_c0", 64'(pkt_count[0]), 64'(0));
    chk("en_c1", 64'(pkt_count[1]), 64'(3'(pkt_exp[1])));

    // Backpressure for 5 cycles mid-packet.
    apply_reset();
    src_on     = 2'b01;
    pkt_len[0] = 6;
    base[0]    = 8'hA5;
    only_dest  = 0;
    for (int c = 0; c < 20; c++) begin
      mr_v = !(c >= 4 && c < 9);
      gstep();
    end
    src_on = 2'b00;
    repeat (8) gstep();
    chk("bp_drained", 64'(sb.size()), 64'(0));

    // Reset after beat 2 of a 4-beat packet.
    apply_reset();
    src_on     = 2'b01;
    pkt_len[0] = 4;
    base[0]    = 8'h40;
    for (int k = 0; k < 20 && n_beat[0] < 2; k++) gstep();
    chk("rst_mid_reached", 64'(n_beat[0]), 64'(2));
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values("rst_mid");
    @(posedge clk);
    #1;
    rst          = 1'b0;
    n_beat[0]    = 0;
    pkt_exp[0]   = 0;
    hold_pending = 1'b0;
    sb.delete();
    for (int k = 0; k < 20; k++) begin
      gstep();
      if (n_beat[0] >= 4) src_on = 2'b00;
    end
    chk("rst_after_drained", 64'(sb.size()), 64'(0));
    chk("rst_after_c0", 64'(pkt_count[0]), 64'(1));
    chk("rst_after_c1", 64'(pkt_count[1]), 64'(0));

    // Single-beat packet on port 1: visible two cycles after first valid.
    apply_reset();
    s_axis_tvalid   = 2'b10;
    s_axis_tlast    = 2'b10;
    s_axis_tdata[1] = {4{8'h3C}};
    s_axis_tkeep[1] = 4'h3;
    @(negedge clk);
    chk("sb1_n_sr", 64'(s_axis_tready), 64'(2'b00));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("sb1_n1_sr", 64'(s_axis_tready), 64'(2'b10));
    chk("sb1_n1_mv", 64'(m_axis_tvalid), 64'(1'b0));
    @(posedge clk);
    #1;
    s_axis_tvalid = 2'b00;
    @(negedge clk);
    chk("sb1_n2_mv", 64'(m_axis_tvalid), 64'(1'b1));
    chk("sb1_n2_ml", 64'(m_axis_tlast), 64'(1'b1));
    chk("sb1_n2_dest", 64'(m_axis_tdest), 64'(1'b1));
    chk("sb1_n2_md", 64'(m_axis_tdata), 64'({4{8'h3C}}));
    chk("sb1_n2_mk", 64'(m_axis_tkeep), 64'(4'h3));
    chk("sb1_n2_c1", 64'(pkt_count[1]), 64'(1));
    @(posedge clk);
    #1;

    // Counter wrap: seven more single-beat packets take port 1 from 1 to 0.
    pkt_exp[1] = 1;
    pkt_len[1] = 1;
    base[1]    = 8'h60;
    src_on     = 2'b10;
    only_dest  = 1;
    for (int k = 0; k < 40 && pkt_exp[1] < 8; k++) gstep();
    src_on = 2'b00;
    chk("wrap_progress", 64'(pkt_exp[1] >= 8), 64'(1'b1));
    repeat (3) gstep();
    chk("wrap_c1", 64'(pkt_count[1]), 64'(0));
    chk("wrap_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 Parameter W_DATA, default 512, tdata width in bits.
REQ-002 Parameter W_KEEP, default W_DATA/8, tkeep width in bits.
REQ-003 Parameter W_CNT, default 32, per-port packet counter width.
REQ-004 axis_aclk  in  1  single clock; all logic is rising-edge.
REQ-005 axis_rst  in  1  reset; asynchronous, active-high.
REQ-006 s_axis_tvalid/tready/tlast  in/out/in  2 each  per-port AXI4-Stream handshake; port 0 = DMA, port 1 = PHY.
REQ-007 s_axis_tdata/tkeep  in  2 x W_DATA / 2 x W_KEEP  per-port payload.
REQ-008 m_axis_tvalid/tready/tlast  out/in/out  1 each  merged output handshake.
REQ-009 m_axis_tdata/tkeep  out  W_DATA/W_KEEP  merged payload.
REQ-010 m_axis_tdest  out  1  index of the source port of the current beat.
REQ-011 cfg_enable  in  2  per-port enable mask; a disabled port is never granted.
REQ-012 cfg_strict  in  1  0 = round-robin, 1 = strict priority with port 0 highest.
REQ-013 pkt_count  out  2 x W_CNT  per-port count of forwarded packets.

Function
REQ-014 FSM states: IDLE, LOCKED.
REQ-015 IDLE: the winner is chosen among ports with tvalid=1 and cfg_enable=1; if a winner exists, the FSM moves to LOCKED next cycle with grant_idx = winner; if none, it stays in IDLE.
REQ-016 Round-robin: the search starts at rr_ptr and wraps modulo 2; strict: the lowest eligible index wins.
REQ-017 All s_axis_tready are 0 in IDLE; in LOCKED, only s_axis_tready[grant_idx] may be 1, equal to (!m_axis_tvalid || m_axis_tready).
REQ-018 An accepted beat is registered into the output stage the same edge; m_axis_* present it the next cycle with tdest=grant_idx.
REQ-019 The output stage holds tdata/tkeep/tlast/tdest stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-020 If the output is drained and no beat is accepted, m_axis_tvalid clears to 0.
REQ-021 Latency: input beat in IDLE at cycle N -> granted and accepted at N+1 -> on output at N+2; full throughput of 1 beat/cycle within a packet.
REQ-022 An accepted beat with tlast=1 returns the FSM to IDLE, sets rr_ptr = grant_idx+1 mod 2, and increments pkt_count[grant_idx].
REQ-023 This gives one mandatory idle cycle on the input side between packets.
REQ-024 pkt_count wraps from 2^W_CNT-1 to 0 with no flag.
REQ-025 A change to cfg_enable or cfg_strict while LOCKED does not affect the current packet; it applies at the next IDLE decision.
REQ-026 A single-beat packet (tlast on the first beat) is legal: LOCKED lasts one accepted cycle.
REQ-027 Source tvalid dropping mid-packet keeps the FSM LOCKED; no other port is granted until tlast.

Reset
REQ-028 While axis_rst=1 (asynchronous), the following hold: state=IDLE, grant_idx=0, rr_ptr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tdest=0, pkt_count=0, all s_axis_tready=0.
REQ-029 Reset mid-packet discards the partial packet and the registered beat; no count is incremented.

Structure
REQ-030 W_DATA, W_KEEP and the port index constants (PORT_DMA=0, PORT_PHY=1) live in the shared package; the FSM state typedef lives in the same package.
REQ-031 One sub-module, axis_output_reg, implements the registered output stage (REQ-018..020).

Verification
REQ-032 Both ports send 3-beat packets continuously, round-robin, all tready=1 -> tdest sequence 0,0,0,1,1,1,0,0,0...; pkt_count increments alternately.
REQ-033 cfg_strict=1, both ports always valid -> only tdest=0 appears; pkt_count[1] stays 0.
REQ-034 cfg_enable=2'b10 while port 0 is valid -> port 0 tready stays 0; only port 1 packets are forwarded.
REQ-035 m_axis_tready held at 0 for 5 cycles mid-packet with tdata=0xA5.. -> the output is stable for all 5 cycles; no beat is lost or duplicated (compare against the input scoreboard).
REQ-036 axis_rst asserted on beat 2 of a 4-beat packet -> all outputs immediately take their REQ-028 values; after release, the next packet is forwarded intact with counts starting at 0.
REQ-037 A single-beat packet on port 1 from IDLE at cycle N -> m_axis_tvalid=1, tlast=1, tdest=1 at cycle N+2; pkt_count[1]=1.
